// File: rtl/mcp_qbus_ctl.sv
// Q-bus cycle controller for the microprocessor data chip.
// Address and data strobes from the data chip become DATI, DATO and DATIO
// bus cycles. The microbus is held in wait until RPLY completes, read data
// is latched for the data chip, and a bus error is raised when RPLY never
// arrives.
module mcp_qbus_ctl #(
    parameter int ASET = 2,
    parameter int TMO  = 64
) (
    input  logic        pin_clk_p,
    input  logic        pin_rst,
    input  logic [15:0] mcp_ado,
    input  logic        mcp_astb,
    input  logic        mcp_dstb,
    input  logic        mcp_rd,
    input  logic        mcp_wr,
    input  logic        mcp_byte,
    output logic        mcp_wi,
    output logic [15:0] mcp_adi,
    input  logic [15:0] bus_dal_i,
    output logic [15:0] bus_dal_o,
    output logic        bus_dal_oe,
    output logic        bus_sync,
    output logic        bus_din,
    output logic        bus_dout,
    output logic        bus_wtbt,
    output logic        bus_bs7,
    input  logic        bus_rply,
    output logic        bus_berr
);

    localparam int CW = (ASET > 1) ? $clog2(ASET) : 1;
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASET,
        S_DPH,
        S_XFER,
        S_RREL
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   timer;
    logic            is_rd;
    logic            is_wr;
    logic            is_byte;
    logic            wr_part;
    logic            rply_m;
    logic            rply_s;

    // Two-flop synchronizer for the asynchronous RPLY line.
    always_ff @(posedge pin_clk_p or posedge pin_rst) begin
        if (pin_rst) begin
            rply_m <= 1'b0;
            rply_s <= 1'b0;
        end else begin
            rply_m <= bus_rply;
            rply_s <= rply_m;
        end
    end

    // Bus cycle sequencer; every bus and microbus output is a register here.
    always_ff @(posedge pin_clk_p or posedge pin_rst) begin
        if (pin_rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            timer      <= '0;
            is_rd      <= 1'b0;
            is_wr      <= 1'b0;
            is_byte    <= 1'b0;
            wr_part    <= 1'b0;
            mcp_wi     <= 1'b0;
            mcp_adi    <= '0;
            bus_dal_o  <= '0;
            bus_dal_oe <= 1'b0;
            bus_sync   <= 1'b0;
            bus_din    <= 1'b0;
            bus_dout   <= 1'b0;
            bus_wtbt   <= 1'b0;
            bus_bs7    <= 1'b0;
            bus_berr   <= 1'b0;
        end else begin
            bus_berr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mcp_astb && (mcp_rd || mcp_wr)) begin
                        is_rd      <= mcp_rd;
                        is_wr      <= mcp_wr;
                        is_byte    <= mcp_byte;
                        bus_dal_o  <= mcp_ado;
                        bus_dal_oe <= 1'b1;
                        bus_bs7    <= (mcp_ado[15:13] == 3'b111);
                        bus_wtbt   <= mcp_wr & ~mcp_rd;
                        mcp_wi     <= 1'b1;
                        cnt        <= CW'(ASET - 1);
                        state      <= S_ASET;
                    end
                end
                S_ASET: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        bus_sync <= 1'b1;
                        bus_bs7  <= 1'b0;
                        bus_wtbt <= 1'b0;
                        wr_part  <= ~is_rd;
                        state    <= S_DPH;
                    end
                end
                S_DPH: begin
                    if (!wr_part) begin
                        bus_dal_oe <= 1'b0;
                        bus_din    <= 1'b1;
                        timer      <= '0;
                        state      <= S_XFER;
                    end else if (mcp_dstb) begin
                        bus_dal_o  <= mcp_ado;
                        bus_dal_oe <= 1'b1;
                        bus_wtbt   <= is_byte;
                        mcp_wi     <= 1'b1;
                        bus_dout   <= 1'b1;
                        timer      <= '0;
                        state      <= S_XFER;
                    end else begin
                        mcp_wi <= 1'b0;
                    end
                end
                S_XFER: begin
                    if (rply_s) begin
                        if (!wr_part) begin
                            mcp_adi <= bus_dal_i;
                        end
                        bus_din  <= 1'b0;
                        bus_dout <= 1'b0;
                        state    <= S_RREL;
                    end else if (timer == TW'(TMO - 1)) begin
                        bus_berr   <= 1'b1;
                        bus_sync   <= 1'b0;
                        bus_din    <= 1'b0;
                        bus_dout   <= 1'b0;
                        bus_dal_oe <= 1'b0;
                        bus_dal_o  <= '0;
                        bus_wtbt   <= 1'b0;
                        bus_bs7    <= 1'b0;
                        mcp_wi     <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RREL: begin
                    if (!rply_s) begin
                        if (!wr_part && is_wr) begin
                            wr_part <= 1'b1;
                            state   <= S_DPH;
                        end else begin
                            bus_sync   <= 1'b0;
                            bus_dal_oe <= 1'b0;
                            bus_wtbt   <= 1'b0;
                            mcp_wi     <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcp_qbus_ctl.sv
// Directed testbench for mcp_qbus_ctl: DATI, DATO byte, DATIO, I/O page,
// ignored strobe, RPLY timeout and reset in the middle of a transfer.
module tb_mcp_qbus_ctl;

    localparam int ASET = 2;
    localparam int TMO  = 64;

    logic        pin_clk_p;
    logic        pin_rst;
    logic [15:0] mcp_ado;
    logic        mcp_astb;
    logic        mcp_dstb;
    logic        mcp_rd;
    logic        mcp_wr;
    logic        mcp_byte;
    logic        mcp_wi;
    logic [15:0] mcp_adi;
    logic [15:0] bus_dal_i;
    logic [15:0] bus_dal_o;
    logic        bus_dal_oe;
    logic        bus_sync;
    logic        bus_din;
    logic        bus_dout;
    logic        bus_wtbt;
    logic        bus_bs7;
    logic        bus_rply;
    logic        bus_berr;

    int          checks = 0;
    int          passed = 0;
    logic [15:0] exp_adi;

    mcp_qbus_ctl #(.ASET(ASET), .TMO(TMO)) dut (
        .pin_clk_p (pin_clk_p),
        .pin_rst   (pin_rst),
        .mcp_ado   (mcp_ado),
        .mcp_astb  (mcp_astb),
        .mcp_dstb  (mcp_dstb),
        .mcp_rd    (mcp_rd),
        .mcp_wr    (mcp_wr),
        .mcp_byte  (mcp_byte),
        .mcp_wi    (mcp_wi),
        .mcp_adi   (mcp_adi),
        .bus_dal_i (bus_dal_i),
        .bus_dal_o (bus_dal_o),
        .bus_dal_oe(bus_dal_oe),
        .bus_sync  (bus_sync),
        .bus_din   (bus_din),
        .bus_dout  (bus_dout),
        .bus_wtbt  (bus_wtbt),
        .bus_bs7   (bus_bs7),
        .bus_rply  (bus_rply),
        .bus_berr  (bus_berr)
    );

    // Free-running clock.
    initial begin
        pin_clk_p = 1'b0;
        forever #5 pin_clk_p = ~pin_clk_p;
    end

    // Global guard so a stuck run still ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog act=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One rising edge, then settle to the falling edge for sampling/driving.
    task automatic cycle();
        @(posedge pin_clk_p);
        @(negedge pin_clk_p);
    endtask

    task automatic test_reset();
        pin_rst = 1'b1;
        repeat (2) @(negedge pin_clk_p);
        checks++; if ({bus_sync, bus_din, bus_dout, bus_wtbt, bus_bs7, bus_berr, bus_dal_oe, mcp_wi} !== 8'h00)
            $display("[TB] FAIL reset_ctl act=%b exp=00000000", {bus_sync, bus_din, bus_dout, bus_wtbt, bus_bs7, bus_berr, bus_dal_oe, mcp_wi});
        else passed++;
        checks++; if (mcp_adi !== 16'h0000) $display("[TB] FAIL reset_adi act=%h exp=0000", mcp_adi); else passed++;
        checks++; if (bus_dal_o !== 16'h0000) $display("[TB] FAIL reset_dal_o act=%h exp=0000", bus_dal_o); else passed++;
        pin_rst = 1'b0;
        exp_adi = 16'h0000;
        cycle();
    endtask

    // Full DATI with RPLY raised right after DIN is seen.
    task automatic test_dati(input logic [15:0] addr, input logic [15:0] data, input string tag);
        logic exp_bs7;
        exp_bs7 = (addr[15:13] == 3'b111);
        mcp_ado = addr; mcp_rd = 1'b1; mcp_wr = 1'b0; mcp_byte = 1'b0; mcp_astb = 1'b1;
        cycle();
        mcp_astb = 1'b0; mcp_rd = 1'b0;
        checks++; if (mcp_wi !== 1'b1) $display("[TB] FAIL %s_wi_addr act=%b exp=1", tag, mcp_wi); else passed++;
        checks++; if (bus_dal_oe !== 1'b1 || bus_dal_o !== addr) $display("[TB] FAIL %s_dal_addr act=%b/%h exp=1/%h", tag, bus_dal_oe, bus_dal_o, addr); else passed++;
        checks++; if (bus_bs7 !== exp_bs7) $display("[TB] FAIL %s_bs7_e0 act=%b exp=%b", tag, bus_bs7, exp_bs7); else passed++;
        cycle();
        checks++; if (bus_sync !== 1'b0 || bus_bs7 !== exp_bs7) $display("[TB] FAIL %s_aset_e1 act=sync%b bs7%b exp=sync0 bs7%b", tag, bus_sync, bus_bs7, exp_bs7); else passed++;
        cycle();
        checks++; if (bus_sync !== 1'b1 || bus_din !== 1'b0 || bus_bs7 !== 1'b0) $display("[TB] FAIL %s_sync_rise act=%b%b%b exp=100", tag, bus_sync, bus_din, bus_bs7); else passed++;
        cycle();
        checks++; if (bus_din !== 1'b1 || bus_dal_oe !== 1'b0) $display("[TB] FAIL %s_din act=din%b oe%b exp=din1 oe0", tag, bus_din, bus_dal_oe); else passed++;
        bus_dal_i = data; bus_rply = 1'b1;
        cycle(); cycle();
        checks++; if (bus_din !== 1'b1) $display("[TB] FAIL %s_din_hold act=%b exp=1", tag, bus_din); else passed++;
        cycle();
        checks++; if (mcp_adi !== data) $display("[TB] FAIL %s_adi act=%h exp=%h", tag, mcp_adi, data); else passed++;
        checks++; if (bus_din !== 1'b0 || bus_sync !== 1'b1 || mcp_wi !== 1'b1) $display("[TB] FAIL %s_rply act=din%b sync%b wi%b exp=din0 sync1 wi1", tag, bus_din, bus_sync, mcp_wi); else passed++;
        exp_adi = data;
        bus_rply = 1'b0;
        cycle(); cycle();
        checks++; if (bus_sync !== 1'b1) $display("[TB] FAIL %s_sync_hold act=%b exp=1", tag, bus_sync); else passed++;
        cycle();
        checks++; if (bus_sync !== 1'b0 || mcp_wi !== 1'b0 || bus_dal_oe !== 1'b0) $display("[TB] FAIL %s_end act=sync%b wi%b oe%b exp=000", tag, bus_sync, mcp_wi, bus_dal_oe); else passed++;
    endtask

    task automatic test_io_page();
        test_dati(16'o177560, 16'h0042, "io");
    endtask

    task automatic test_ignored_astb();
        mcp_ado = 16'o003000; mcp_rd = 1'b0; mcp_wr = 1'b0; mcp_astb = 1'b1;
        cycle();
        mcp_astb = 1'b0;
        cycle(); cycle();
        checks++; if (mcp_wi !== 1'b0 || bus_dal_oe !== 1'b0 || bus_sync !== 1'b0) $display("[TB] FAIL ign_astb act=wi%b oe%b sync%b exp=000", mcp_wi, bus_dal_oe, bus_sync); else passed++;
    endtask

    task automatic test_dato_byte();
        mcp_ado = 16'o004000; mcp_rd = 1'b0; mcp_wr = 1'b1; mcp_byte = 1'b1; mcp_astb = 1'b1;
        cycle();
        mcp_astb = 1'b0; mcp_wr = 1'b0; mcp_byte = 1'b0;
        checks++; if (bus_wtbt !== 1'b1) $display("[TB] FAIL dato_wtbt_addr act=%b exp=1", bus_wtbt); else passed++;
        cycle(); cycle();
        checks++; if (bus_sync !== 1'b1 || bus_wtbt !== 1'b0) $display("[TB] FAIL dato_sync act=sync%b wtbt%b exp=sync1 wtbt0", bus_sync, bus_wtbt); else passed++;
        cycle();
        checks++; if (mcp_wi !== 1'b0 || bus_dout !== 1'b0 || bus_din !== 1'b0) $display("[TB] FAIL dato_wait_dstb act=wi%b dout%b din%b exp=000", mcp_wi, bus_dout, bus_din); else passed++;
        mcp_ado = 16'h00A5; mcp_dstb = 1'b1;
        cycle();
        mcp_dstb = 1'b0;
        checks++; if (bus_dal_o !== 16'h00A5 || bus_dal_oe !== 1'b1) $display("[TB] FAIL dato_data act=%h/%b exp=00a5/1", bus_dal_o, bus_dal_oe); else passed++;
        checks++; if (bus_dout !== 1'b1 || bus_wtbt !== 1'b1 || mcp_wi !== 1'b1) $display("[TB] FAIL dato_dout act=dout%b wtbt%b wi%b exp=111", bus_dout, bus_wtbt, mcp_wi); else passed++;
        bus_rply = 1'b1;
        cycle(); cycle(); cycle();
        checks++; if (bus_dout !== 1'b0 || bus_sync !== 1'b1) $display("[TB] FAIL dato_rply act=dout%b sync%b exp=dout0 sync1", bus_dout, bus_sync); else passed++;
        bus_rply = 1'b0;
        cycle(); cycle(); cycle();
        checks++; if (bus_sync !== 1'b0 || mcp_wi !== 1'b0) $display("[TB] FAIL dato_end act=sync%b wi%b exp=00", bus_sync, mcp_wi); else passed++;
        checks++; if (mcp_adi !== exp_adi) $display("[TB] FAIL dato_adi_keep act=%h exp=%h", mcp_adi, exp_adi); else passed++;
    endtask

    task automatic test_datio();
        mcp_ado = 16'o002000; mcp_rd = 1'b1; mcp_wr = 1'b1; mcp_byte = 1'b0; mcp_astb = 1'b1;
        cycle();
        mcp_astb = 1'b0; mcp_rd = 1'b0; mcp_wr = 1'b0;
        checks++; if (bus_wtbt !== 1'b0) $display("[TB] FAIL datio_wtbt_addr act=%b exp=0", bus_wtbt); else passed++;
        cycle(); cycle(); cycle();
        checks++; if (bus_din !== 1'b1 || bus_sync !== 1'b1) $display("[TB] FAIL datio_din act=din%b sync%b exp=11", bus_din, bus_sync); else passed++;
        bus_dal_i = 16'hBEEF; bus_rply = 1'b1;
        cycle(); cycle(); cycle();
        checks++; if (mcp_adi !== 16'hBEEF || bus_din !== 1'b0) $display("[TB] FAIL datio_read act=%h din%b exp=beef din0", mcp_adi, bus_din); else passed++;
        exp_adi = 16'hBEEF;
        bus_rply = 1'b0;
        cycle(); cycle(); cycle();
        checks++; if (bus_sync !== 1'b1 || mcp_wi !== 1'b1) $display("[TB] FAIL datio_mid act=sync%b wi%b exp=11", bus_sync, mcp_wi); else passed++;
        cycle();
        checks++; if (bus_sync !== 1'b1 || mcp_wi !== 1'b0 || bus_dout !== 1'b0) $display("[TB] FAIL datio_wait_dstb act=sync%b wi%b dout%b exp=100", bus_sync, mcp_wi, bus_dout); else passed++;
        mcp_ado = 16'h5555; mcp_dstb = 1'b1;
        cycle();
        mcp_dstb = 1'b0;
        checks++; if (bus_dout !== 1'b1 || bus_dal_o !== 16'h5555 || bus_wtbt !== 1'b0 || bus_din !== 1'b0) $display("[TB] FAIL datio_write act=dout%b %h wtbt%b din%b exp=1 5555 0 0", bus_dout, bus_dal_o, bus_wtbt, bus_din); else passed++;
        bus_rply = 1'b1;
        cycle(); cycle(); cycle();
        checks++; if (bus_dout !== 1'b0 || bus_sync !== 1'b1) $display("[TB] FAIL datio_rply act=dout%b sync%b exp=01", bus_dout, bus_sync); else passed++;
        bus_rply = 1'b0;
        cycle(); cycle(); cycle();
        checks++; if (bus_sync !== 1'b0 || mcp_wi !== 1'b0 || mcp_adi !== 16'hBEEF) $display("[TB] FAIL datio_end act=sync%b wi%b %h exp=0 0 beef", bus_sync, mcp_wi, mcp_adi); else passed++;
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        mcp_ado = 16'o001000; mcp_rd = 1'b1; mcp_wr = 1'b0; mcp_astb = 1'b1;
        cycle();
        mcp_astb = 1'b0; mcp_rd = 1'b0;
        cycle(); cycle(); cycle();
        checks++; if (bus_din !== 1'b1) $display("[TB] FAIL tmo_din act=%b exp=1", bus_din); else passed++;
        for (int i = 1; i < TMO; i++) begin
            cycle();
            if (bus_berr !== 1'b0 && early == 0) early = i;
        end
        checks++; if (early != 0) $display("[TB] FAIL tmo_early act=cycle%0d exp=none", early); else passed++;
        cycle();
        checks++; if (bus_berr !== 1'b1) $display("[TB] FAIL tmo_berr act=%b exp=1", bus_berr); else passed++;
        checks++; if ({bus_sync, bus_din, bus_dout, bus_dal_oe, bus_wtbt, bus_bs7, mcp_wi} !== 7'b0) $display("[TB] FAIL tmo_outs act=%b exp=0000000", {bus_sync, bus_din, bus_dout, bus_dal_oe, bus_wtbt, bus_bs7, mcp_wi}); else passed++;
        checks++; if (mcp_adi !== exp_adi) $display("[TB] FAIL tmo_adi act=%h exp=%h", mcp_adi, exp_adi); else passed++;
        cycle();
        checks++; if (bus_berr !== 1'b0) $display("[TB] FAIL tmo_berr_pulse act=%b exp=0", bus_berr); else passed++;
    endtask

    task automatic test_reset_in_xfer();
        mcp_ado = 16'o001000; mcp_rd = 1'b1; mcp_wr = 1'b0; mcp_astb = 1'b1;
        cycle();
        mcp_astb = 1'b0; mcp_rd = 1'b0;
        cycle(); cycle(); cycle();
        checks++; if (bus_din !== 1'b1 || bus_sync !== 1'b1) $display("[TB] FAIL rstx_pre act=din%b sync%b exp=11", bus_din, bus_sync); else passed++;
        #2 pin_rst = 1'b1;
        #1;
        checks++; if (bus_sync !== 1'b0 || bus_din !== 1'b0 || mcp_wi !== 1'b0) $display("[TB] FAIL rstx_async act=sync%b din%b wi%b exp=000", bus_sync, bus_din, mcp_wi); else passed++;
        checks++; if (mcp_adi !== 16'h0000) $display("[TB] FAIL rstx_adi act=%h exp=0000", mcp_adi); else passed++;
        @(negedge pin_clk_p);
        pin_rst = 1'b0;
        exp_adi = 16'h0000;
        cycle();
        test_dati(16'o001000, 16'h7777, "post_rst");
    endtask

    // Test sequence.
    initial begin
        pin_rst = 1'b1;
        mcp_ado = '0; mcp_astb = 1'b0; mcp_dstb = 1'b0;
        mcp_rd = 1'b0; mcp_wr = 1'b0; mcp_byte = 1'b0;
        bus_dal_i = '0; bus_rply = 1'b0;
        exp_adi = '0;
        test_reset();
        $display("[TB] DATI");
        test_dati(16'o001000, 16'h1234, "dati");
        $display("[TB] DATO byte");
        test_dato_byte();
        $display("[TB] DATIO");
        test_datio();
        $display("[TB] I/O page");
        test_io_page();
        $display("[TB] ignored strobe");
        test_ignored_astb();
        $display("[TB] timeout");
        test_timeout();
        $display("[TB] reset in XFER");
        test_reset_in_xfer();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
